fetch_unit: RTL and testbench

- Parametrised instruction fetch stage. It keeps its own PC, issues word requests to the instruction memory over a valid/ready request channel, and accepts responses on a valid-only channel.
- Fetched words are buffered with their PC in an instruction queue of depth IQ_DEPTH, which feeds Decode over a valid/ready handshake.
- Supports branch/jump redirect with queue flush and discard of an in-flight response.
- Sits between the PC/branch logic (redirect source) and Decode.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   Keeps its own PC and issues one word request at a time to instruction
//   memory. Returned words are buffered with their PC in a small FIFO that
//   feeds Decode. A redirect (branch/jump) reloads the PC, flushes the FIFO
//   and arranges for an in-flight response to be dropped.
//
// Handshakes:
//   mem_req_*  : valid/ready. A transfer happens on a rising edge where
//                mem_req_valid && mem_req_ready. Once raised, mem_req_valid
//                and mem_req_addr stay stable until accepted; only a
//                redirect (or reset) withdraws a pending request.
//   mem_rsp_*  : valid only, no backpressure. At most one response is
//                outstanding, and space for it was reserved at issue time.
//   inst_*     : valid/ready. The head is consumed on a rising edge where
//                inst_valid && inst_ready; inst_data/inst_pc are meaningless
//                while inst_valid is low.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   redirect_valid/_pc     reload PC (low two bits ignored) and flush
//   mem_req_valid/_ready   request handshake, mem_req_addr = current PC
//   mem_rsp_valid/_data    response word for the outstanding request
//   inst_valid/_ready      queue head handshake towards Decode
//   inst_data, inst_pc     queue head contents
//   iq_count               queue occupancy
//   done_fetch             one-cycle pulse after a word enters the queue
//   state_dbg              current FSM state (S_REQ=0, S_WAIT=1, S_DISCARD=2)
module fetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 32,
  parameter int IQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_rsp_valid,
  input  logic [INST_W-1:0]             mem_rsp_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INST_W-1:0]             inst_data,
  output logic [ADDR_W-1:0]             inst_pc,
  output logic [$clog2(IQ_DEPTH):0]     iq_count,
  output logic                          done_fetch,
  output logic [1:0]                    state_dbg
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] req_pc;

  logic [ADDR_W-1:0] q_pc   [IQ_DEPTH];
  logic [INST_W-1:0] q_data [IQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic req_fire;
  logic push;
  logic pop;

  // Issue is blocked during reset, while the queue has no free slot, and in
  // the cycle a redirect arrives (that request would target the old path).
  assign mem_req_valid = (state == S_REQ) && (count < FULL_CNT) &&
                         !redirect_valid && !rst;
  assign mem_req_addr  = pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response in the redirect cycle belongs to the abandoned path.
  assign push = (state == S_WAIT) && mem_rsp_valid && !redirect_valid && !rst;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = q_data[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign iq_count   = count;
  assign state_dbg  = state;

  // Next-state and next-PC.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
      case (state)
        S_REQ:     state_next = S_REQ;
        // Accepted request still owes a response: drop it unless it is here.
        S_WAIT:    state_next = mem_rsp_valid ? S_REQ : S_DISCARD;
        S_DISCARD: state_next = mem_rsp_valid ? S_REQ : S_DISCARD;
        default:   state_next = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            state_next = S_WAIT;
            pc_next    = pc + ADDR_W'(4);
          end
        end
        S_WAIT:    if (mem_rsp_valid) state_next = S_REQ;
        S_DISCARD: if (mem_rsp_valid) state_next = S_REQ;
        default:   state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done_fetch <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      done_fetch <= push;
      if (req_fire) begin
        req_pc <= pc;
      end
      if (redirect_valid) begin
        // Flush: any same-cycle pop counts as consumed, pushes are blocked.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset; entries are only read once written.
  // A push into an empty queue is not bypassed to the head output.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_data[wr_ptr] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a reference model.
// The memory responder answers each accepted request after "lat" cycles with
// data = addr ^ KEY. The model tracks PC, outstanding-response status and
// the instruction queue contents as a plain queue of {pc, data} words.
module tb_fetch_unit;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [IW-1:0] mem_rsp_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic [$clog2(DEPTH):0] iq_count;
  logic          done_fetch;
  logic [1:0]    state_dbg;

  fetch_unit #(
    .ADDR_W(AW), .INST_W(IW), .IQ_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .iq_count(iq_count), .done_fetch(done_fetch), .state_dbg(state_dbg)
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: m_out 0 = nothing owed, 1 = live response owed,
  // 2 = response owed that must be thrown away
  logic [31:0] m_pc     = RPC;
  logic [31:0] m_req_pc = RPC;
  int          m_out    = 0;
  logic        m_done   = 1'b0;
  logic [63:0] exp_q[$];

  // memory responder and bookkeeping for literal checks
  logic [31:0] sched[int];
  int          cyc = 0;
  int          lat = 1;
  bit          chk_en = 0;
  int          done_cnt = 0;
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sched.exists(cyc)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = sched[cyc] ^ KEY;
      sched.delete(cyc);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
  end

  // compare process: inputs are stable here (driven 1 time unit after the
  // rising edge), so both model evaluation and DUT sampling are race-free
  always @(negedge clk) begin
    logic e_rv;
    bit   m_pop;
    e_rv = !rst && (m_out == 0) && (exp_q.size() < DEPTH) && !redirect_valid;
    if (chk_en) begin
      check("req_valid",  mem_req_valid, e_rv);
      check("req_addr",   mem_req_addr,  m_pc);
      check("inst_valid", inst_valid,    exp_q.size() > 0);
      check("iq_count",   iq_count,      exp_q.size());
      check("done_fetch", done_fetch,    m_done);
      if (exp_q.size() > 0) begin
        check("inst_pc",   inst_pc,   exp_q[0][63:32]);
        check("inst_data", inst_data, exp_q[0][31:0]);
      end
    end
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      pop_pc_q.push_back(inst_pc);
      pop_data_q.push_back(inst_data);
    end
    if (done_fetch) done_cnt++;
    if (!rst && mem_req_valid && mem_req_ready) sched[cyc + lat] = mem_req_addr;

    // advance the model by the coming rising edge
    m_pop = (exp_q.size() > 0) && inst_ready;
    if (rst) begin
      m_pc   = RPC;
      m_out  = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_out != 0) m_out = mem_rsp_valid ? 0 : 2;
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_out == 1 && mem_rsp_valid) begin
          exp_q.push_back({m_req_pc, mem_rsp_data});
          m_done = 1'b1;
          m_out  = 0;
        end else if (m_out == 2 && mem_rsp_valid) begin
          m_out = 0;
        end else if (e_rv && mem_req_ready) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_out    = 1;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_addr == a) found = 1;
    end
    check("wait_req_timeout", found, 1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_req_ready = 1'b1;
    inst_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    lat = 1;
    tick();
    chk_en = 1;
    @(negedge clk);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_count", iq_count, 0);

    // reset / stream
    tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    pop_pc_q.delete();
    pop_data_q.delete();
    done_cnt = 0;
    repeat (14) tick();
    check("stream_pops", pop_pc_q.size() >= 4, 1);
    if (pop_pc_q.size() >= 4) begin
      check("stream_pc0", pop_pc_q[0], 64'h100);
      check("stream_pc1", pop_pc_q[1], 64'h104);
      check("stream_pc2", pop_pc_q[2], 64'h108);
      check("stream_pc3", pop_pc_q[3], 64'h10C);
      check("stream_d0",  pop_data_q[0], 64'hA5A5A4A5);
      check("stream_d1",  pop_data_q[1], 64'hA5A5A4A1);
    end
    check("stream_done_per_word", done_cnt, pop_pc_q.size());

    // backpressure
    do_reset();
    inst_ready = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("bp_count", iq_count, 4);
    check("bp_req_valid", mem_req_valid, 0);
    check("bp_head_pc", inst_pc, 64'h100);
    check("bp_head_data", inst_data, 64'hA5A5A4A5);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    @(negedge clk);
    check("bp_req_after_pop", mem_req_valid, 1);
    check("bp_addr_after_pop", mem_req_addr, 64'h110);
    check("bp_count_after_pop", iq_count, 3);
    check("bp_head_after_pop", inst_pc, 64'h104);
    repeat (6) tick();

    // redirect while waiting for a response
    do_reset();
    inst_ready = 1'b0;
    lat = 3;
    wait_req(32'h104);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2002;
    d0 = done_cnt;
    tick();
    redirect_valid = 1'b0;
    wait_req(32'h2000);
    check("rw_no_done", done_cnt, d0);
    check("rw_count", iq_count, 0);
    check("rw_inst_valid", inst_valid, 0);
    repeat (6) tick();

    // redirect coincident with the response
    do_reset();
    inst_ready = 1'b1;
    lat = 1;
    wait_req(32'h104);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rc_req_valid", mem_req_valid, 1);
    check("rc_addr", mem_req_addr, 64'h3000);
    check("rc_count", iq_count, 0);
    repeat (4) tick();

    // stalled request
    do_reset();
    inst_ready = 1'b1;
    lat = 1;
    wait_req(32'h104);
    tick();
    mem_req_ready = 1'b0;
    wait_req(32'h108);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", mem_req_valid, 1);
      check("stall_addr", mem_req_addr, 64'h108);
    end
    @(posedge clk);
    #1;
    mem_req_ready = 1'b1;
    tick();
    @(negedge clk);
    check("stall_pc_after", mem_req_addr, 64'h10C);
    check("stall_valid_after", mem_req_valid, 0);
    repeat (4) tick();

    // PC wrap, then reset in the middle of a request
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    lat = 2;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_valid", mem_req_valid, 1);
    check("wrap_addr", mem_req_addr, 64'hFFFFFFFC);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("wrap_next_addr", mem_req_addr, 64'h0);
    check("wrap_valid_in_rst", mem_req_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_addr", mem_req_addr, 64'h100);
    check("mrst_valid", mem_req_valid, 1);
    check("mrst_count", iq_count, 0);
    tick();
    @(negedge clk);
    check("mrst_late_rsp_count", iq_count, 0);
    check("mrst_late_rsp_done", done_fetch, 0);
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
